// File: rtl/tank_move_sched.sv
// Per-frame move scheduler for the two player tanks: decodes keys, shares the
// tile-map RAM between tanks and commits at most one tile step per tank per frame.
module tank_move_sched #(
  parameter int unsigned GRID_W        = 20,
  parameter int unsigned GRID_H        = 15,
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter int unsigned P1_TX0        = 1,
  parameter int unsigned P1_TY0        = 13,
  parameter int unsigned P2_TX0        = 18,
  parameter int unsigned P2_TY0        = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  output logic [8:0] map_addr,
  output logic       map_rd,
  input  logic [3:0] map_data,
  output logic [9:0] tank1_x,
  output logic [9:0] tank1_y,
  output logic [9:0] tank2_x,
  output logic [9:0] tank2_y,
  output logic [1:0] face1,
  output logic [1:0] face2,
  output logic       busy,
  output logic       move_done
);

  localparam int unsigned TW = 5;
  localparam int unsigned CW = 8;
  localparam int unsigned KW = 8;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 4;
  localparam logic [TW-1:0] XMAX = TW'(GRID_W - 1);
  localparam logic [TW-1:0] YMAX = TW'(GRID_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_RD,
    S_WAIT,
    S_CHK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0] tx_q [2];
  logic [TW-1:0] ty_q [2];
  logic [TW-1:0] tx_d [2];
  logic [TW-1:0] ty_d [2];
  logic [1:0]    face_q [2];
  logic [1:0]    face_d [2];
  logic [1:0]    dir_q [2];
  logic [1:0]    dir_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [KW-1:0] prev_q [2];
  logic [KW-1:0] prev_d [2];
  logic [1:0]    req_q, req_d;
  logic          cur_q, cur_d;
  logic          second_q, second_d;
  logic          first_q, first_d;
  logic [TW-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] map_addr_d;
  logic          map_rd_d, busy_d, done_d;

  logic [KW-1:0] key [2];
  logic [2:0]    dec [2];
  logic [TW-1:0] cx, cy, nx, ny;
  logic          oob, advance, other;

  // Keycode decode: {valid, direction}, direction 0 up, 1 right, 2 down, 3 left
  function automatic logic [2:0] decode_p1(input logic [KW-1:0] k);
    case (k)
      8'h1A:   return 3'b100;
      8'h07:   return 3'b101;
      8'h16:   return 3'b110;
      8'h04:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] decode_p2(input logic [KW-1:0] k);
    case (k)
      8'h52:   return 3'b100;
      8'h4F:   return 3'b101;
      8'h51:   return 3'b110;
      8'h50:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  assign key[0] = keycode1;
  assign key[1] = keycode2;
  assign dec[0] = decode_p1(keycode1);
  assign dec[1] = decode_p2(keycode2);

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    face_d     = face_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    req_d      = req_q;
    cur_d      = cur_q;
    second_d   = second_q;
    first_d    = first_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    data_d     = data_q;
    map_addr_d = map_addr;
    map_rd_d   = 1'b0;
    other      = ~cur_q;
    cx         = tx_q[cur_q];
    cy         = ty_q[cur_q];
    nx         = cx;
    ny         = cy;
    oob        = 1'b0;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          for (int p = 0; p < 2; p++) begin
            req_d[p] = 1'b0;
            dir_d[p] = dec[p][1:0];
            if (dec[p][2]) begin
              if (key[p] != prev_q[p] || cnt_q[p] == '0) begin
                req_d[p] = 1'b1;
                cnt_d[p] = CW'(REPEAT_FRAMES - 1);
              end else begin
                cnt_d[p] = cnt_q[p] - CW'(1);
              end
            end else begin
              cnt_d[p] = '0;
            end
            prev_d[p] = key[p];
          end
          cur_d    = first_q;
          first_d  = ~first_q;
          second_d = 1'b0;
          state_d  = S_SEL;
        end
      end

      S_SEL: begin
        if (!req_q[cur_q]) begin
          advance = 1'b1;
        end else begin
          face_d[cur_q] = dir_q[cur_q];
          case (dir_q[cur_q])
            2'd0:    if (cy == '0)   oob = 1'b1; else ny = cy - TW'(1);
            2'd1:    if (cx >= XMAX) oob = 1'b1; else nx = cx + TW'(1);
            2'd2:    if (cy >= YMAX) oob = 1'b1; else ny = cy + TW'(1);
            default: if (cx == '0)   oob = 1'b1; else nx = cx - TW'(1);
          endcase
          if (oob) begin
            advance = 1'b1;
          end else begin
            tgt_x_d    = nx;
            tgt_y_d    = ny;
            map_addr_d = AW'(ny) * AW'(GRID_W) + AW'(nx);
            map_rd_d   = 1'b1;
            state_d    = S_RD;
          end
        end
      end

      S_RD: state_d = S_WAIT;

      S_WAIT: begin
        data_d  = map_data;
        state_d = S_CHK;
      end

      // The other tank's committed tile blocks, so the second-served tank sees the first's move
      S_CHK: begin
        if (data_q == '0 && !(tgt_x_q == tx_q[other] && tgt_y_q == ty_q[other])) begin
          tx_d[cur_q] = tgt_x_q;
          ty_d[cur_q] = tgt_y_q;
        end
        advance = 1'b1;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (second_q) begin
        state_d = S_DONE;
      end else begin
        second_d = 1'b1;
        cur_d    = ~cur_q;
        state_d  = S_SEL;
      end
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tx_q[0]   <= TW'(P1_TX0);
      ty_q[0]   <= TW'(P1_TY0);
      tx_q[1]   <= TW'(P2_TX0);
      ty_q[1]   <= TW'(P2_TY0);
      face_q[0] <= 2'd0;
      face_q[1] <= 2'd2;
      dir_q[0]  <= 2'd0;
      dir_q[1]  <= 2'd0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      prev_q[0] <= '0;
      prev_q[1] <= '0;
      req_q     <= '0;
      cur_q     <= 1'b0;
      second_q  <= 1'b0;
      first_q   <= 1'b0;
      tgt_x_q   <= '0;
      tgt_y_q   <= '0;
      data_q    <= '0;
      map_addr  <= '0;
      map_rd    <= 1'b0;
      busy      <= 1'b0;
      move_done <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      face_q    <= face_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      req_q     <= req_d;
      cur_q     <= cur_d;
      second_q  <= second_d;
      first_q   <= first_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      data_q    <= data_d;
      map_addr  <= map_addr_d;
      map_rd    <= map_rd_d;
      busy      <= busy_d;
      move_done <= done_d;
    end
  end

  assign tank1_x = {tx_q[0], 5'd0};
  assign tank1_y = {ty_q[0], 5'd0};
  assign tank2_x = {tx_q[1], 5'd0};
  assign tank2_y = {ty_q[1], 5'd0};
  assign face1   = face_q[0];
  assign face2   = face_q[1];

endmodule
